// File: rtl/export_sched.sv
// Export scheduler: round-robin grant of decoded export instructions, one VGPR
// read per active channel, and one export-buffer beat per channel read.
`timescale 1ns/1ps

package export_sched_pkg;
  typedef struct packed {
    logic [3:0] en;
    logic [5:0] target;
    logic       compr;
    logic       done;
    logic       vm;
    logic [7:0] vsrc3;
    logic [7:0] vsrc2;
    logic [7:0] vsrc1;
    logic [7:0] vsrc0;
  } export_inst_t;
endpackage

module export_sched
  import export_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic         [NUM_REQ-1:0]          req_valid,
  input  export_inst_t [NUM_REQ-1:0]          req_inst,
  output logic         [NUM_REQ-1:0]          req_ready,
  output logic                                vgpr_rd_en,
  output logic         [7:0]                  vgpr_rd_addr,
  input  logic                                vgpr_rd_valid,
  input  logic         [DATA_W-1:0]           vgpr_rd_data,
  output logic                                exp_wr_valid,
  input  logic                                exp_wr_ready,
  output logic         [5:0]                  exp_wr_target,
  output logic         [1:0]                  exp_wr_chan,
  output logic         [DATA_W-1:0]           exp_wr_data,
  output logic                                exp_wr_last,
  output logic                                exp_wr_done,
  output logic                                exp_wr_vm,
  output logic                                exp_wr_null,
  output logic                                exp_wr_src,
  output logic                                busy
);

  localparam int SRC_W = 1;

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

  state_t              state, state_nxt;
  logic [SRC_W-1:0]    rr_ptr;
  export_inst_t        inst_p0;
  logic [SRC_W-1:0]    src_p0;
  logic [1:0]          chan_p0;
  logic                null_p0;
  logic [DATA_W-1:0]   data_p1;

  logic                gnt_vld;
  logic [SRC_W-1:0]    gnt_idx;
  logic [SRC_W-1:0]    cand;
  logic [2:0]          first_g;
  logic [2:0]          next_c;
  logic                more;

  // Compressed exports pack two halves per dword, so only channels 0/1 exist.
  function automatic logic [3:0] act_mask(input export_inst_t inst);
    if (inst.compr)
      return {2'b00, |inst.en[3:2], |inst.en[1:0]};
    return inst.en;
  endfunction

  // Returns {found, channel} for the lowest active channel at or above 'from'.
  function automatic logic [2:0] first_from(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int c = 3; c >= 0; c--) begin
      if (mask[c] && (3'(c) >= from))
        res = {1'b1, 2'(c)};
    end
    return res;
  endfunction

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = SRC_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    first_g = first_from(act_mask(req_inst[gnt_idx]), 3'd0);
    next_c  = first_from(act_mask(inst_p0), {1'b0, chan_p0} + 3'd1);
    more    = next_c[2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gnt_vld) state_nxt = first_g[2] ? RD : WR;
      RD:   state_nxt = WAIT;
      WAIT: if (vgpr_rd_valid) state_nxt = WR;
      WR:   if (exp_wr_ready) state_nxt = more ? RD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction latch stage (p0) and read-data capture stage (p1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      inst_p0 <= '0;
      src_p0  <= '0;
      chan_p0 <= '0;
      null_p0 <= 1'b0;
      data_p1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            inst_p0 <= req_inst[gnt_idx];
            src_p0  <= gnt_idx;
            rr_ptr  <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            chan_p0 <= first_g[2] ? first_g[1:0] : 2'd0;
            null_p0 <= ~first_g[2];
            data_p1 <= '0;
          end
        end
        WAIT: if (vgpr_rd_valid) data_p1 <= vgpr_rd_data;
        WR:   if (exp_wr_ready && more) chan_p0 <= next_c[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready     = '0;
    vgpr_rd_en    = 1'b0;
    vgpr_rd_addr  = '0;
    exp_wr_valid  = 1'b0;
    exp_wr_target = '0;
    exp_wr_chan   = '0;
    exp_wr_data   = '0;
    exp_wr_last   = 1'b0;
    exp_wr_done   = 1'b0;
    exp_wr_vm     = 1'b0;
    exp_wr_null   = 1'b0;
    exp_wr_src    = 1'b0;
    busy          = (state != IDLE);
    case (state)
      // Gating with reset keeps the grant quiet while reset is held low.
      IDLE: if (gnt_vld && reset) req_ready[gnt_idx] = 1'b1;
      RD: begin
        vgpr_rd_en = 1'b1;
        case (chan_p0)
          2'd0:    vgpr_rd_addr = inst_p0.vsrc0;
          2'd1:    vgpr_rd_addr = inst_p0.vsrc1;
          2'd2:    vgpr_rd_addr = inst_p0.vsrc2;
          default: vgpr_rd_addr = inst_p0.vsrc3;
        endcase
      end
      WR: begin
        exp_wr_valid  = 1'b1;
        exp_wr_target = inst_p0.target;
        exp_wr_chan   = chan_p0;
        exp_wr_data   = data_p1;
        exp_wr_last   = ~more;
        exp_wr_done   = inst_p0.done & ~more;
        exp_wr_vm     = inst_p0.vm;
        exp_wr_null   = null_p0;
        exp_wr_src    = src_p0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_export_sched.sv
// Directed scoreboard bench for export_sched: expected reads and beats are
// queued as instructions are issued and popped as the DUT produces them.
`timescale 1ns/1ps

module tb_export_sched;
  import export_sched_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic [5:0]  target;
    logic [1:0]  chan;
    logic [31:0] data;
    logic        last;
    logic        done;
    logic        vm;
    logic        nul;
    logic        src;
  } beat_t;

  logic                           clk = 1'b0;
  logic                           reset;
  logic         [NUM_REQ-1:0]     req_valid;
  export_inst_t [NUM_REQ-1:0]     req_inst;
  logic         [NUM_REQ-1:0]     req_ready;
  logic                           vgpr_rd_en;
  logic         [7:0]             vgpr_rd_addr;
  logic                           vgpr_rd_valid;
  logic         [DATA_W-1:0]      vgpr_rd_data;
  logic                           exp_wr_valid;
  logic                           exp_wr_ready;
  logic         [5:0]             exp_wr_target;
  logic         [1:0]             exp_wr_chan;
  logic         [DATA_W-1:0]      exp_wr_data;
  logic                           exp_wr_last;
  logic                           exp_wr_done;
  logic                           exp_wr_vm;
  logic                           exp_wr_null;
  logic                           exp_wr_src;
  logic                           busy;

  beat_t       beat_q[$];
  logic [7:0]  addr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_lat = 1;
  int          grant_cyc = 0;
  int          first_valid_cyc = -1;

  export_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_inst(req_inst), .req_ready(req_ready),
    .vgpr_rd_en(vgpr_rd_en), .vgpr_rd_addr(vgpr_rd_addr),
    .vgpr_rd_valid(vgpr_rd_valid), .vgpr_rd_data(vgpr_rd_data),
    .exp_wr_valid(exp_wr_valid), .exp_wr_ready(exp_wr_ready),
    .exp_wr_target(exp_wr_target), .exp_wr_chan(exp_wr_chan), .exp_wr_data(exp_wr_data),
    .exp_wr_last(exp_wr_last), .exp_wr_done(exp_wr_done), .exp_wr_vm(exp_wr_vm),
    .exp_wr_null(exp_wr_null), .exp_wr_src(exp_wr_src), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vdata(input logic [7:0] a);
    return {8'hC0, a, ~a, a ^ 8'h5A};
  endfunction

  function automatic export_inst_t mk(input logic [3:0] en, input logic compr, input logic done,
                                      input logic vm, input logic [5:0] tgt, input logic [7:0] v0,
                                      input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
    export_inst_t i;
    i.en = en; i.compr = compr; i.done = done; i.vm = vm; i.target = tgt;
    i.vsrc0 = v0; i.vsrc1 = v1; i.vsrc2 = v2; i.vsrc3 = v3;
    return i;
  endfunction

  task automatic expect_inst(input export_inst_t in, input logic src);
    logic [3:0] m;
    logic [7:0] a;
    beat_t      b;
    int         last_c;
    m = in.compr ? {2'b00, in.en[3] | in.en[2], in.en[1] | in.en[0]} : in.en;
    last_c = -1;
    for (int c = 0; c < 4; c++) if (m[c]) last_c = c;
    b.target = in.target; b.vm = in.vm; b.src = src;
    if (last_c < 0) begin
      b.chan = 2'd0; b.data = '0; b.last = 1'b1; b.done = in.done; b.nul = 1'b1;
      beat_q.push_back(b);
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (m[c]) begin
          a = (c == 0) ? in.vsrc0 : (c == 1) ? in.vsrc1 : (c == 2) ? in.vsrc2 : in.vsrc3;
          addr_q.push_back(a);
          b.chan = 2'(c); b.data = vdata(a); b.last = (c == last_c);
          b.done = in.done && (c == last_c); b.nul = 1'b0;
          beat_q.push_back(b);
        end
      end
    end
  endtask

  task automatic wait_grant(input int r);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 50) begin @(negedge clk); n++; end
    check("grant", req_ready, 64'(1 << r));
    grant_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic issue(input int r, input export_inst_t in);
    expect_inst(in, r[0]);
    req_inst[r]  = in;
    req_valid[r] = 1'b1;
    wait_grant(r);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((busy || beat_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check({tag, "_beats_left"}, beat_q.size(), 0);
    check({tag, "_reads_left"}, addr_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // VGPR responder: returns data rd_lat cycles after each read request
  initial begin
    logic [7:0] ra;
    vgpr_rd_valid = 1'b0;
    vgpr_rd_data  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (vgpr_rd_en === 1'b1) begin
        ra = vgpr_rd_addr;
        if (addr_q.size() > 0) check("rd_addr", vgpr_rd_addr, addr_q.pop_front());
        else check("rd_unexpected", vgpr_rd_en, 0);
        repeat (rd_lat) @(posedge clk);
        #1;
        vgpr_rd_valid = 1'b1;
        vgpr_rd_data  = vdata(ra);
        @(posedge clk); #1;
        vgpr_rd_valid = 1'b0;
        vgpr_rd_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Beat monitor
  initial begin
    beat_t ob;
    forever begin
      @(negedge clk);
      if (exp_wr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_wr_valid === 1'b1 && exp_wr_ready === 1'b1) begin
        ob = {exp_wr_target, exp_wr_chan, exp_wr_data, exp_wr_last, exp_wr_done,
              exp_wr_vm, exp_wr_null, exp_wr_src};
        if (beat_q.size() > 0) check("beat", ob, beat_q.pop_front());
        else check("beat_unexpected", exp_wr_valid, 0);
      end
    end
  end

  initial begin
    export_inst_t i0, i1;
    logic [45:0]  snap;
    int           n;

    reset = 1'b0; req_valid = '0; req_inst = '0; exp_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 2'b11;
    #1;
    check("reset_outputs", {req_ready, busy, vgpr_rd_en, vgpr_rd_addr, exp_wr_valid, exp_wr_data,
                            exp_wr_last, exp_wr_done, exp_wr_null, exp_wr_src, exp_wr_target,
                            exp_wr_chan, exp_wr_vm}, 0);
    req_valid = '0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Non-compressed, channels 0/1/3, minimum latency
    rd_lat = 1; first_valid_cyc = -1;
    issue(0, mk(4'b1011, 1'b0, 1'b1, 1'b1, 6'h21, 8'h10, 8'h11, 8'h12, 8'h13));
    wait_done("t1");
    check("t1_latency", 64'(first_valid_cyc - grant_cyc), 3);

    // Compressed, upper half only, slower reads
    rd_lat = 3;
    issue(1, mk(4'b1100, 1'b1, 1'b1, 1'b0, 6'h0C, 8'h21, 8'h22, 8'h23, 8'h24));
    wait_done("t2");

    // Null export
    rd_lat = 1;
    issue(0, mk(4'b0000, 1'b0, 1'b1, 1'b1, 6'h09, 8'h01, 8'h02, 8'h03, 8'h04));
    wait_done("t3");

    // Export buffer back-pressure with another requester waiting
    exp_wr_ready = 1'b0;
    issue(0, mk(4'b0011, 1'b0, 1'b0, 1'b0, 6'h05, 8'h30, 8'h31, 8'h32, 8'h33));
    n = 0;
    @(negedge clk);
    while (!exp_wr_valid && n < 20) begin @(negedge clk); n++; end
    snap = {exp_wr_valid, exp_wr_target, exp_wr_chan, exp_wr_data, exp_wr_last, exp_wr_done,
            exp_wr_vm, exp_wr_null, exp_wr_src};
    check("stall_valid", exp_wr_valid, 1);
    i1 = mk(4'b0000, 1'b0, 1'b0, 1'b1, 6'h3F, 8'h00, 8'h00, 8'h00, 8'h00);
    expect_inst(i1, 1'b1);
    req_inst[1] = i1; req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", {exp_wr_valid, exp_wr_target, exp_wr_chan, exp_wr_data, exp_wr_last,
                           exp_wr_done, exp_wr_vm, exp_wr_null, exp_wr_src}, snap);
      check("stall_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    exp_wr_ready = 1'b1;
    wait_grant(1);
    req_valid[1] = 1'b0;
    wait_done("t4");

    // Round-robin fairness from a freshly reset pointer
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    i0 = mk(4'b0001, 1'b0, 1'b1, 1'b0, 6'h11, 8'h50, 8'h00, 8'h00, 8'h00);
    i1 = mk(4'b0001, 1'b0, 1'b0, 1'b1, 6'h12, 8'h60, 8'h00, 8'h00, 8'h00);
    req_inst[0] = i0; req_inst[1] = i1;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      expect_inst((k % 2 == 0) ? i0 : i1, 1'(k % 2));
      wait_grant(k % 2);
    end
    req_valid = '0;
    wait_done("t5");

    // Reset while waiting on a read; the late return must be ignored
    rd_lat = 6;
    i0 = mk(4'b0001, 1'b0, 1'b1, 1'b1, 6'h2A, 8'h40, 8'h00, 8'h00, 8'h00);
    addr_q.push_back(8'h40);
    req_inst[0] = i0; req_valid[0] = 1'b1;
    wait_grant(0);
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 2'b11;
    #1;
    check("rst_async", {req_ready, busy, vgpr_rd_en, exp_wr_valid, exp_wr_data, exp_wr_last,
                        exp_wr_done, exp_wr_null, exp_wr_target}, 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("rst_idle", busy, 0);
    check("rst_reads_left", addr_q.size(), 0);
    rd_lat = 1;
    issue(0, mk(4'b0100, 1'b0, 1'b1, 1'b0, 6'h33, 8'h00, 8'h00, 8'h77, 8'h00));
    wait_done("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
